// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to TXDATA queue bytes in a small FIFO,
// loads from STATUS return {overflow, busy, full, empty}.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        hit,
    output logic        tx,
    output logic        busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [PW:0]   DEPTH_C  = (PW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]   count_reg, count_next;
    logic [1:0]    state_reg, state_next;
    logic [7:0]    sh_reg, sh_next;
    logic [2:0]    bit_reg, bit_next;
    logic [CW-1:0] cyc_reg, cyc_next;
    logic          overflow_reg, tx_reg, busy_reg;
    logic          tx_next, busy_next;
    logic          full, empty, push_req, push, pop, bit_done;
    logic          unused_wdata;

    assign unused_wdata = ^WriteData[31:8];

    assign full     = (count_reg == DEPTH_C);
    assign empty    = (count_reg == '0);
    // Fullness is judged before any same-edge pop, so a push at full is always dropped.
    assign push_req = MemWrite && (DataAdr == BASE_ADDR);
    assign push     = push_req && !full;
    assign bit_done = (cyc_reg == CYC_LAST);

    assign hit  = (DataAdr == BASE_ADDR) || (DataAdr == BASE_ADDR + 32'd4);
    assign tx   = tx_reg;
    assign busy = busy_reg;

    always_comb begin
        ReadData = '0;
        if (DataAdr == BASE_ADDR + 32'd4)
            ReadData = {28'b0, overflow_reg, busy_reg, full, empty};
    end

    always_comb begin
        state_next = state_reg;
        sh_next    = sh_reg;
        bit_next   = bit_reg;
        cyc_next   = cyc_reg;
        pop        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    sh_next    = mem[rd_ptr_reg];
                    cyc_next   = '0;
                    state_next = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    cyc_next   = '0;
                    bit_next   = '0;
                    state_next = S_DATA;
                end else begin
                    cyc_next = cyc_reg + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cyc_next = '0;
                    sh_next  = {1'b0, sh_reg[7:1]};
                    bit_next = bit_reg + 3'd1;
                    if (bit_reg == 3'd7)
                        state_next = S_STOP;
                end else begin
                    cyc_next = cyc_reg + CW'(1);
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    cyc_next = '0;
                    // Chain straight into the next start bit when more data is waiting.
                    if (!empty) begin
                        pop        = 1'b1;
                        sh_next    = mem[rd_ptr_reg];
                        state_next = S_START;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    cyc_next = cyc_reg + CW'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + (PW + 1)'(1);
            2'b01:   count_next = count_reg - (PW + 1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // Outputs are registered from next-state values so tx falls on the popping edge.
    always_comb begin
        tx_next = 1'b1;
        if (state_next == S_START)
            tx_next = 1'b0;
        else if (state_next == S_DATA)
            tx_next = sh_next[0];
        busy_next = (state_next != S_IDLE) || (count_next != '0);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= WriteData[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            state_reg    <= S_IDLE;
            sh_reg       <= '0;
            bit_reg      <= '0;
            cyc_reg      <= '0;
            overflow_reg <= 1'b0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            if (push_req && full)
                overflow_reg <= 1'b1;
            count_reg <= count_next;
            state_reg <= state_next;
            sh_reg    <= sh_next;
            bit_reg   <= bit_next;
            cyc_reg   <= cyc_next;
            tx_reg    <= tx_next;
            busy_reg  <= busy_next;
        end
    end

endmodule
